// File: rtl/tlcd_text_buffer.sv
// tlcd_text_buffer: byte-stream front end maintaining the two 16-char LCD line images.
// A printable byte at column 15 wraps to the next line, or scrolls from line 1, only when
// TLCD_BUF_AUTOWRAP_EN is defined. Otherwise the cursor sticks at column 15.
module tlcd_text_buffer #(
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic         CLK,
    input  logic         RESETN,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [7:0]   IN_CHAR,
    input  logic         CLEAR,
    output logic [127:0] TEXT_STRING_UPPER,
    output logic [127:0] TEXT_STRING_LOWER,
    output logic         CURSOR_ROW,
    output logic [3:0]   CURSOR_COL,
    output logic         BUSY,
    output logic         UPDATE
);

    localparam int unsigned COL_W = 4;
    localparam int unsigned IDX_W = 5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCROLL = 2'd1;
    localparam logic [1:0] ST_CLR    = 2'd2;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam logic [COL_W-1:0] COL_LAST  = 4'd15;
    localparam logic [IDX_W-1:0] SCROLL_LAST = 5'd15;
    localparam logic [IDX_W-1:0] CLR_LAST    = 5'd31;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             row_d;
    logic [COL_W-1:0] col_d;
    logic             upd_d;
    logic             wr_en;
    logic             wr_row;
    logic [COL_W-1:0] wr_col;
    logic [7:0]       wr_char;

    // Column 0 sits in the top byte, so the LSB of a cell is (15-col)*8.
    function automatic logic [6:0] cell_lsb(input logic [COL_W-1:0] c);
        return {~c, 3'b000};
    endfunction

    assign IN_READY = (state_q == ST_IDLE) && !CLEAR;
    assign BUSY     = (state_q != ST_IDLE);

    // State register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, cursor, cell-write request and completion pulse.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = CURSOR_ROW;
        col_d   = CURSOR_COL;
        upd_d   = 1'b0;
        wr_en   = 1'b0;
        wr_row  = CURSOR_ROW;
        wr_col  = CURSOR_COL;
        wr_char = FILL_CHAR;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (CLEAR) begin
                    state_d = ST_CLR;
                    row_d   = 1'b0;
                    col_d   = '0;
                end else if (IN_VALID) begin
                    case (IN_CHAR)
                        CH_CR: begin
                            col_d = '0;
                        end
                        CH_LF: begin
                            row_d = 1'b1;
                            col_d = '0;
                            if (CURSOR_ROW) begin
                                state_d = ST_SCROLL;
                            end
                        end
                        CH_BS: begin
                            if (CURSOR_COL != '0) begin
                                col_d  = CURSOR_COL - 4'd1;
                                wr_en  = 1'b1;
                                wr_col = CURSOR_COL - 4'd1;
                                upd_d  = 1'b1;
                            end else if (CURSOR_ROW) begin
                                row_d  = 1'b0;
                                col_d  = COL_LAST;
                                wr_en  = 1'b1;
                                wr_row = 1'b0;
                                wr_col = COL_LAST;
                                upd_d  = 1'b1;
                            end
                        end
                        CH_FF: begin
                            state_d = ST_CLR;
                            row_d   = 1'b0;
                            col_d   = '0;
                        end
                        default: begin
                            wr_en   = 1'b1;
                            wr_char = IN_CHAR;
                            upd_d   = 1'b1;
                            if (CURSOR_COL != COL_LAST) begin
                                col_d = CURSOR_COL + 4'd1;
                            end
`ifdef TLCD_BUF_AUTOWRAP_EN
                            else if (CURSOR_ROW) begin
                                // The pulse is deferred until the scroll completes.
                                state_d = ST_SCROLL;
                                col_d   = '0;
                                upd_d   = 1'b0;
                            end else begin
                                row_d = 1'b1;
                                col_d = '0;
                            end
`else
`endif
                        end
                    endcase
                end
            end
            ST_SCROLL: begin
                idx_d = idx_q + 5'd1;
                if (idx_q == SCROLL_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    upd_d   = 1'b1;
                end
            end
            ST_CLR: begin
                wr_en  = 1'b1;
                wr_row = idx_q[4];
                wr_col = idx_q[3:0];
                idx_d  = idx_q + 5'd1;
                if (idx_q == CLR_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    upd_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Cursor, sequencing index and completion pulse.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            idx_q      <= '0;
            CURSOR_ROW <= 1'b0;
            CURSOR_COL <= '0;
            UPDATE     <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            CURSOR_ROW <= row_d;
            CURSOR_COL <= col_d;
            UPDATE     <= upd_d;
        end
    end

    // Line images: single-cell writes, plus one column moved up per scroll cycle.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            TEXT_STRING_UPPER <= {16{FILL_CHAR}};
            TEXT_STRING_LOWER <= {16{FILL_CHAR}};
        end else begin
            if (wr_en) begin
                if (wr_row) begin
                    TEXT_STRING_LOWER[cell_lsb(wr_col) +: 8] <= wr_char;
                end else begin
                    TEXT_STRING_UPPER[cell_lsb(wr_col) +: 8] <= wr_char;
                end
            end
            if (state_q == ST_SCROLL) begin
                TEXT_STRING_UPPER[cell_lsb(idx_q[3:0]) +: 8] <=
                    TEXT_STRING_LOWER[cell_lsb(idx_q[3:0]) +: 8];
                TEXT_STRING_LOWER[cell_lsb(idx_q[3:0]) +: 8] <= FILL_CHAR;
            end
        end
    end

endmodule

// File: tb/tb_tlcd_text_buffer.sv
// Bench for tlcd_text_buffer: directed scenarios plus random traffic against a line-array model.
module tb_tlcd_text_buffer;

    localparam logic [7:0] FILL = 8'h20;
`ifdef TLCD_BUF_AUTOWRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_char = 8'h00;
    logic         clear = 1'b0;
    logic         in_ready;
    logic [127:0] upper, lower;
    logic         cur_row;
    logic [3:0]   cur_col;
    logic         busy;
    logic         update;

    tlcd_text_buffer #(.FILL_CHAR(FILL)) dut (
        .CLK(clk), .RESETN(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_CHAR(in_char), .CLEAR(clear), .TEXT_STRING_UPPER(upper),
        .TEXT_STRING_LOWER(lower), .CURSOR_ROW(cur_row), .CURSOR_COL(cur_col),
        .BUSY(busy), .UPDATE(update)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: final line contents are applied at once; busy time is just a countdown.
    logic [7:0] m_line [2][16];
    int m_row, m_col, m_busy;
    bit m_upd;

    task automatic m_blank();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++) m_line[r][c] = FILL;
    endtask

    task automatic m_reset();
        m_blank();
        m_row = 0; m_col = 0; m_busy = 0; m_upd = 1'b0;
    endtask

    task automatic m_scroll();
        for (int c = 0; c < 16; c++) begin
            m_line[0][c] = m_line[1][c];
            m_line[1][c] = FILL;
        end
        m_row = 1; m_col = 0; m_busy = 16;
    endtask

    task automatic m_edge(input logic v, input logic [7:0] ch, input logic clr);
        m_upd = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) m_upd = 1'b1;
        end else if (clr || (v && ch == 8'h0C)) begin
            m_blank();
            m_row = 0; m_col = 0; m_busy = 32;
        end else if (v) begin
            if (ch == 8'h0D) begin
                m_col = 0;
            end else if (ch == 8'h0A) begin
                if (m_row == 1) m_scroll();
                else begin m_row = 1; m_col = 0; end
            end else if (ch == 8'h08) begin
                if (m_col > 0) begin
                    m_col--; m_line[m_row][m_col] = FILL; m_upd = 1'b1;
                end else if (m_row == 1) begin
                    m_row = 0; m_col = 15; m_line[0][15] = FILL; m_upd = 1'b1;
                end
            end else begin
                m_line[m_row][m_col] = ch;
                m_upd = 1'b1;
                if (m_col < 15) m_col++;
                else if (WRAP) begin
                    if (m_row == 0) begin m_row = 1; m_col = 0; end
                    else begin m_scroll(); m_upd = 1'b0; end
                end
            end
        end
    endtask

    function automatic logic [127:0] m_image(input int r);
        logic [127:0] v;
        for (int c = 0; c < 16; c++) v[127-8*c -: 8] = m_line[r][c];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", 128'(in_ready), 128'(m_busy == 0 && !clear));
        chk("busy", 128'(busy), 128'(m_busy != 0));
        chk("update", 128'(update), 128'(m_upd));
        chk("cursor_row", 128'(cur_row), 128'(m_row));
        chk("cursor_col", 128'(cur_col), 128'(m_col));
        if (m_busy == 0) begin
            chk("upper", upper, m_image(0));
            chk("lower", lower, m_image(1));
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] c, input logic clr);
        in_valid = v; in_char = c; clear = clr;
        @(posedge clk);
        m_edge(v, c, clr);
        #1;
        check_all();
    endtask

    task automatic do_clear();
        cyc(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 32; i++) cyc(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [127:0] exp_v;
        int cnt, lows, sent, guard;
        string hello;

        // Reset values while RESETN is held low.
        m_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // "Hello, World!" back to back.
        hello = "Hello, World!";
        cnt = 0; lows = 0;
        for (int i = 0; i < hello.len(); i++) begin
            if (!in_ready) lows++;
            cyc(1'b1, hello[i], 1'b0);
            if (update) cnt++;
        end
        cyc(1'b0, 8'h00, 1'b0);
        exp_v = "Hello, World!   ";
        chk("hello_upper", upper, exp_v);
        chk("hello_updates", 128'(cnt), 128'd13);
        chk("hello_ready_low", 128'(lows), 128'd0);

        // Custom glyphs, LF, "AB".
        do_clear();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b1, 8'h0A, 1'b0);
        cyc(1'b1, "A", 1'b0);
        cyc(1'b1, "B", 1'b0);
        exp_v = "AB              ";
        chk("glyph_lower", lower, exp_v);

        // 33 accepted 'x' with IN_VALID held; count not-ready cycles.
        do_clear();
        sent = 0; lows = 0; guard = 0;
        while (sent < 33 && guard < 200) begin
            if (in_ready) sent++; else lows++;
            cyc(1'b1, "x", 1'b0);
            guard++;
        end
        chk("x33_bound", 128'(guard < 200), 128'd1);
        for (int i = 0; i < 20; i++) begin
            if (!in_ready) lows++;
            cyc(1'b0, 8'h00, 1'b0);
        end
        chk("x33_ready_low", 128'(lows), WRAP ? 128'd16 : 128'd0);

        // Backspace across the line boundary, then at home.
        do_clear();
        for (int i = 0; i < 15; i++) cyc(1'b1, "a", 1'b0);
        cyc(1'b1, 8'h0A, 1'b0);
        cyc(1'b1, 8'h08, 1'b0);
        chk("bs_upper_col15", 128'(upper[7:0]), 128'(FILL));
        for (int i = 0; i < 15; i++) cyc(1'b1, 8'h08, 1'b0);
        cyc(1'b1, 8'h08, 1'b0);
        chk("bs_home_no_update", 128'(update), 128'd0);

        // CLEAR wins over a valid byte.
        cyc(1'b1, "Q", 1'b1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) cnt++;
            cyc(1'b0, 8'h00, 1'b0);
        end
        chk("clear_busy_cycles", 128'(cnt), 128'd32);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            int sel;
            logic [7:0] ch;
            sel = int'($urandom_range(0, 99));
            if (sel < 8) ch = 8'h0A;
            else if (sel < 14) ch = 8'h08;
            else if (sel < 18) ch = 8'h0D;
            else if (sel < 19) ch = 8'h0C;
            else ch = 8'($urandom_range(0, 127));
            cyc(1'($urandom_range(0, 3) != 0), ch, 1'($urandom_range(0, 99) == 0));
        end
        for (int i = 0; i < 34; i++) cyc(1'b0, 8'h00, 1'b0);

        // Reset dropped asynchronously on the 7th scroll cycle.
        do_clear();
        cyc(1'b1, 8'h0A, 1'b0);
        cyc(1'b1, "z", 1'b0);
        cyc(1'b1, 8'h0A, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        chk("post_reset_ready", 128'(in_ready), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
